// File: rtl/sum4bit_serial_pkg.sv
// rtl/sum4bit_serial_pkg.sv - shared state encoding and default width for the bit-serial adder
// Package sum_serial_pkg: FSM state type and the default operand width.
package sum_serial_pkg;

  localparam int SUM_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/sum4bit_serial_if.sv
// rtl/sum4bit_serial_if.sv - start/busy/done handshake bundle for the bit-serial adder
// Signals: start, n1, n2 (requester -> adder); busy, done, result, Co, Overflow (adder -> requester).
// Modports: master drives the request side, slave is the adder.
interface sum4bit_serial_if
  import sum_serial_pkg::*;
#(
  parameter int WIDTH = SUM_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] n1;
  logic [WIDTH-1:0] n2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             Co;
  logic             Overflow;

  modport master (
    output start, n1, n2,
    input  busy, done, result, Co, Overflow
  );

  modport slave (
    input  start, n1, n2,
    output busy, done, result, Co, Overflow
  );

endinterface

// File: rtl/full_adder_1bit.sv
// rtl/full_adder_1bit.sv - single-bit combinational full adder
// Ports: a, b, cin (inputs); s = sum bit, cout = carry out.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/sum4bit_serial.sv
// rtl/sum4bit_serial.sv - bit-serial two's-complement adder, LSB first, one bit per clock
// Ports: clk, rst_n (async active-low); bus (slave) carries start/n1/n2 in and
// busy/done/result/Co/Overflow out. done pulses for one cycle after the last bit.
module sum4bit_serial
  import sum_serial_pkg::*;
#(
  parameter int WIDTH = SUM_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  sum4bit_serial_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             co_q, ov_q;

  logic fa_s, fa_cout;
  logic load, last_bit;

  full_adder_1bit u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_cout)
  );

  // A new request is only accepted when no addition is in flight.
  assign load     = bus.start && (state_q == S_IDLE || state_q == S_DONE);
  assign last_bit = (state_q == S_RUN) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = bus.start ? S_RUN : S_IDLE;
      S_RUN:   state_d = (cnt == LAST) ? S_DONE : S_RUN;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else if (load) begin
      a_sh   <= bus.n1;
      b_sh   <= bus.n2;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
    end else if (state_q == S_RUN) begin
      // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at index 0.
      sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      carry  <= fa_cout;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        // Published outputs only move here, so they never show a partial sum.
        result_q <= {fa_s, sum_sh[WIDTH-1:1]};
        co_q     <= fa_cout;
        ov_q     <= carry ^ fa_cout;
      end
    end
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.Co       = co_q;
  assign bus.Overflow = ov_q;

endmodule

// File: tb/tb_sum4bit_serial.sv
// tb/tb_sum4bit_serial.sv - self-checking bench for sum4bit_serial
module tb_sum4bit_serial;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sum4bit_serial_if #(.WIDTH(W)) bus ();

  sum4bit_serial #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer addition and signed range test.
  task automatic model(input int a, input int b, output int sum, output int co, output int ov);
    int sa, sb, ss;
    sum = (a + b) % (1 << W);
    co  = ((a + b) >= (1 << W)) ? 1 : 0;
    sa  = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb  = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    ss  = sa + sb;
    ov  = (ss > (1 << (W - 1)) - 1 || ss < -(1 << (W - 1))) ? 1 : 0;
  endtask

  // Called #1 after an edge; steps edges until done, bounded.
  task automatic wait_done(output int cyc, output int bz, output int moved);
    logic [W-1:0] r0;
    r0    = bus.result;
    cyc   = 0;
    moved = 0;
    bz    = bus.busy ? 1 : 0;
    while (!bus.done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.busy) bz++;
      if (!bus.done && bus.result !== r0) moved = 1;
    end
  endtask

  task automatic check_result(input string tag, input int a, input int b);
    int es, ec, eo;
    model(a, b, es, ec, eo);
    chk({tag, ".result"}, 32'(bus.result), 32'(es));
    chk({tag, ".Co"}, 32'(bus.Co), 32'(ec));
    chk({tag, ".Overflow"}, 32'(bus.Overflow), 32'(eo));
  endtask

  task automatic run_op(input string tag, input int a, input int b);
    int cyc, bz, moved;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n1    = W'(a);
    bus.n2    = W'(b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(cyc, bz, moved);
    chk({tag, ".latency"}, 32'(cyc), 32'(W));
    chk({tag, ".busy_cycles"}, 32'(bz), 32'(W));
    chk({tag, ".no_partial"}, 32'(moved), 32'd0);
    check_result(tag, a, b);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int cyc, bz, moved, seen;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.n1    = '0;
    bus.n2    = '0;

    repeat (2) @(negedge clk);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.result", 32'(bus.result), 32'd0);
    chk("reset.Co", 32'(bus.Co), 32'd0);
    chk("reset.Overflow", 32'(bus.Overflow), 32'd0);
    rst_n = 1'b1;

    run_op("3+4", 3, 4);
    run_op("7+1", 7, 1);
    run_op("15+1", 15, 1);
    run_op("8+8", 8, 8);

    // Start held high; operands change mid-run; back-to-back launch from DONE.
    @(negedge clk);
    bus.start = 1'b1;
    bus.n1    = W'(2);
    bus.n2    = W'(3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.n1 = W'(5);
    bus.n2 = W'(5);
    wait_done(cyc, bz, moved);
    chk("b2b1.latency", 32'(cyc), 32'(W - 1));
    check_result("b2b1", 2, 3);
    @(posedge clk);
    #1;
    chk("b2b2.launch_busy", 32'(bus.busy), 32'd1);
    chk("b2b2.launch_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    wait_done(cyc, bz, moved);
    chk("b2b2.latency", 32'(cyc), 32'(W));
    check_result("b2b2", 5, 5);
    @(posedge clk);
    #1;

    // Reset asserted while bit 2 of 6+6 is pending.
    @(negedge clk);
    bus.start = 1'b1;
    bus.n1    = W'(6);
    bus.n2    = W'(6);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.result", 32'(bus.result), 32'd0);
    chk("rst.Co", 32'(bus.Co), 32'd0);
    chk("rst.Overflow", 32'(bus.Overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1;
    end
    chk("rst.no_done", 32'(seen), 32'd0);
    run_op("9+2", 9, 2);

    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        run_op($sformatf("sweep_%0d+%0d", a, b), a, b);
      end
    end

    for (int i = 0; i < 40; i++) begin
      int ra, rb;
      ra = int'($urandom_range(0, (1 << W) - 1));
      rb = int'($urandom_range(0, (1 << W) - 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_op($sformatf("rand%0d_%0d+%0d", i, ra, rb), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
